phys_reg_freelist: RTL
======================

# phys_reg_freelist

Physical register free list for the rename stage. Hands out destination physical register addresses (prd) to rename, and takes back freed registers at commit. On flush it rolls the speculative allocation pointer back to the committed pointer. P0 is hard-wired zero, so it is never allocated and never reinserted. The block supplies the prd addresses that the execution units later write back into the physical register file.

## Interface
Parameters:
- REG_SIZE, 64, number of physical registers; must be a power of two.
- REG_SIZE_WIDTH, 6, log2(REG_SIZE).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- alloc_ready  out  1  at least one speculatively free register is available.
- alloc_prd  out  REG_SIZE_WIDTH  register handed out if alloc_valid is asserted this cycle.
- alloc_valid  in  1  rename consumes alloc_prd this cycle.
- commit_valid  in  1  an instruction that allocated a prd has retired.
- release_valid  in  1  return release_prd to the free list.
- release_prd  in  REG_SIZE_WIDTH  old prd of the retiring instruction.
- flush  in  1  squash all uncommitted allocations.
- free_count  out  REG_SIZE_WIDTH+1  speculative free count.
- release_err  out  1  one-cycle pulse when a release is dropped because the list is full.

## Operation
- Storage is a circular FIFO of REG_SIZE entries, each REG_SIZE_WIDTH wide.
- It has three pointers, each REG_SIZE_WIDTH+1 bits (a wrap bit plus the index):
  - spec_head: next entry to allocate.
  - commit_head: oldest entry not yet committed out.
  - tail: next entry to write on release.
- Derived values:
  - free_count = tail − spec_head.
  - occupancy = tail − commit_head; it never exceeds REG_SIZE−1.
- Reset state:
  - fifo[i] = i+1 for i = 0..REG_SIZE−2; fifo[REG_SIZE−1] = 0 (unused).
  - spec_head = 0, commit_head = 0, tail = REG_SIZE−1.
  - Resulting outputs: alloc_ready = 1, alloc_prd = 1, free_count = REG_SIZE−1, release_err = 0.
- alloc_ready = (free_count != 0).
- alloc_prd = fifo[spec_head index]. It is combinational from state and is meaningful only when alloc_ready = 1.
- Allocate: alloc_valid & alloc_ready & ~flush → spec_head += 1. Asserting alloc_valid while alloc_ready = 0 is ignored.
- Commit: commit_valid & (commit_head != spec_head) → commit_head += 1. A commit when the two pointers are equal is ignored.
- Release: release_valid & (release_prd != 0):
  - If occupancy < REG_SIZE−1: write fifo[tail] ← release_prd, then tail += 1.
  - Otherwise: drop the release and pulse release_err.
  - A release of P0 is silently ignored.
- Flush: spec_head ← commit_head after this cycle's commit is applied, i.e. commit_head + commit_accepted. Any alloc_valid in the flush cycle is ignored. A release in the flush cycle is still accepted.
- Simultaneous events are all processed in the same cycle in this order: commit, release, then allocate or flush.
- A register released this cycle is not visible to allocation until the next cycle; there is no bypass. A release while free_count = 0 leaves alloc_ready = 0 for that cycle.

## Timing
- alloc_prd and alloc_ready are valid combinationally from registered state. The next address appears one cycle after an accepted allocation.
- Pointers, FIFO writes, and release_err are registered and take effect at the next rising edge.
- free_count reflects the registered pointers: zero-latency read, one-cycle update.
- Back-to-back allocation every cycle is supported until the list is empty.
- Pointer wrap-around is handled by modulo-2^(REG_SIZE_WIDTH+1) arithmetic; there are no special cases.
- Asserting reset_n low at any time immediately forces the reset state, discarding in-flight allocations, commits, and releases. Deassertion is synchronised externally.

## Structure
- Shared package phys_reg_pkg holds:
  - the REG_SIZE and REG_SIZE_WIDTH defaults;
  - the prd address typedef;
  - the pointer typedef (REG_SIZE_WIDTH+1 bits);
  - the constant P0 = 0.
- Single module with no sub-modules. The FIFO array and the pointer logic sit in one sequential process plus combinational outputs.

## Test plan
- Reset with no other stimulus → alloc_prd = 1, alloc_ready = 1, free_count = 63, release_err = 0.
- alloc_valid held for 63 cycles → alloc_prd sequence 1..63; then alloc_ready = 0 and free_count = 0; a further alloc_valid changes nothing.
- From empty, release_prd = 5 with release_valid → next cycle alloc_ready = 1, alloc_prd = 5, free_count = 1. Same-cycle alloc_valid is not honoured.
- From reset:
  - Allocate 3 (prds 1, 2, 3), then commit 1.
  - Flush with commit_valid in the same cycle → alloc_prd = 3, free_count = 61.
  - Flush without commit → alloc_prd = 2, free_count = 62.
- release_prd = 0 → no state change. Release at reset (occupancy 63) → release_err pulses for 1 cycle and free_count stays 63.
- Assert reset_n low mid-allocation (after 10 allocations) → outputs return asynchronously to the reset values, with no clock edge required.

Source files
------------

// File: rtl/phys_reg_pkg.sv
// phys_reg_pkg: shared sizes, prd/pointer types and the hard-wired-zero register for the free list
package phys_reg_pkg;
  localparam int REG_SIZE = 64;
  localparam int REG_SIZE_WIDTH = 6;
  typedef logic [REG_SIZE_WIDTH-1:0] prd_t;
  typedef logic [REG_SIZE_WIDTH:0] ptr_t;
  localparam prd_t P0 = '0;
endpackage

// File: rtl/phys_reg_freelist.sv
// phys_reg_freelist: circular free list of physical registers with speculative alloc, commit and flush rollback
// Ports: clk/reset_n (async active-low); alloc_ready/alloc_prd/alloc_valid hand prds to rename;
// commit_valid retires one allocation; release_valid/release_prd return a freed prd; flush rolls
// speculative allocations back to the committed point; free_count is the speculative free count;
// release_err pulses when a release is dropped because the list is full.
module phys_reg_freelist
  import phys_reg_pkg::*;
#(
  parameter int REG_SIZE = phys_reg_pkg::REG_SIZE,
  parameter int REG_SIZE_WIDTH = phys_reg_pkg::REG_SIZE_WIDTH
) (
  input  logic                      clk,
  input  logic                      reset_n,
  output logic                      alloc_ready,
  output logic [REG_SIZE_WIDTH-1:0] alloc_prd,
  input  logic                      alloc_valid,
  input  logic                      commit_valid,
  input  logic                      release_valid,
  input  logic [REG_SIZE_WIDTH-1:0] release_prd,
  input  logic                      flush,
  output logic [REG_SIZE_WIDTH:0]   free_count,
  output logic                      release_err
);
  logic [REG_SIZE_WIDTH-1:0] fifo [REG_SIZE];
  logic [REG_SIZE_WIDTH:0] spec_head, commit_head, tail, commit_next, occupancy;
  logic commit_ok, rel, rel_ok, alloc_ok;
  assign free_count = tail - spec_head;
  assign alloc_ready = |free_count;
  assign alloc_prd = fifo[spec_head[REG_SIZE_WIDTH-1:0]];
  assign commit_ok = commit_valid && (commit_head != spec_head);
  assign commit_next = commit_head + (REG_SIZE_WIDTH+1)'(commit_ok);
  // Commit is applied before release, so a same-cycle retirement makes room for the release.
  assign occupancy = tail - commit_next;
  assign rel = release_valid && (release_prd != REG_SIZE_WIDTH'(P0));
  assign rel_ok = rel && (occupancy < (REG_SIZE_WIDTH+1)'(REG_SIZE-1));
  assign alloc_ok = alloc_valid && alloc_ready && !flush;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      // i+1 truncates to 0 for the last, unused entry.
      for (int i = 0; i < REG_SIZE; i++) fifo[i] <= REG_SIZE_WIDTH'(i+1);
      spec_head <= '0;
      commit_head <= '0;
      tail <= (REG_SIZE_WIDTH+1)'(REG_SIZE-1);
      release_err <= 1'b0;
    end else begin
      if (rel_ok) fifo[tail[REG_SIZE_WIDTH-1:0]] <= release_prd;
      commit_head <= commit_next;
      tail <= tail + (REG_SIZE_WIDTH+1)'(rel_ok);
      spec_head <= flush ? commit_next : spec_head + (REG_SIZE_WIDTH+1)'(alloc_ok);
      release_err <= rel && !rel_ok;
    end
  end
endmodule
